// File: rtl/qpu_time_pkg.sv
// Shared widths, state encoding and event bundle for the QPU timing path
// (time queue / event queue consumers and the event issue stage).
package qpu_time_pkg;

  localparam int QPU_TIME_WIDTH       = 32;
  localparam int QPU_EVENT_WIRE_WIDTH = 8;
  localparam int QPU_EVENT_NUM        = 12;
  localparam int QPU_EV_CNT_WIDTH     = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic [QPU_EVENT_WIRE_WIDTH-1:0] wires;
    logic [QPU_EVENT_NUM-1:0]        oprand;
  } qpu_event_t;

endpackage

// File: rtl/qpu_time_cnt.sv
// Run-gated timeline counter: counts run cycles, saturates at all-ones,
// reloads to 1 on an issue so the next interval is measured from the strobe.
module qpu_time_cnt
  import qpu_time_pkg::*;
#(
  parameter int WIDTH = QPU_TIME_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic             load1_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = WIDTH'(1);
    end else if (run_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/qpu_exu_event_issue.sv
// Event issue stage: pops tiq/evq pairs into a head register and strobes each
// event to the quantum front-end once its relative interval has elapsed.
module qpu_exu_event_issue
  import qpu_time_pkg::*;
#(
  parameter int TIME_WIDTH       = QPU_TIME_WIDTH,
  parameter int EVENT_WIRE_WIDTH = QPU_EVENT_WIRE_WIDTH,
  parameter int EVENT_NUM        = QPU_EVENT_NUM,
  parameter int CNT_WIDTH        = QPU_EV_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run_i,
  input  logic                        clr_i,
  input  logic                        tiq_rd_valid,
  input  logic [TIME_WIDTH-1:0]       tiq_rd_data,
  output logic                        tiq_rd_ready,
  input  logic                        evq_rd_valid,
  input  logic [EVENT_WIRE_WIDTH-1:0] evq_rd_data,
  input  logic [EVENT_NUM-1:0]        evq_rd_oprand,
  output logic                        evq_rd_ready,
  output logic                        ev_o_valid,
  output logic [EVENT_WIRE_WIDTH-1:0] ev_o_data,
  output logic [EVENT_NUM-1:0]        ev_o_oprand,
  output logic                        late_o,
  output logic                        sync_err_o,
  output logic                        busy_o,
  output logic [CNT_WIDTH-1:0]        ev_cnt_o
);

  issue_state_e                state_q;
  logic [TIME_WIDTH-1:0]       head_w_q;
  logic [EVENT_WIRE_WIDTH-1:0] head_data_q;
  logic [EVENT_NUM-1:0]        head_oprand_q;
  logic                        ev_valid_q;
  logic [EVENT_WIRE_WIDTH-1:0] ev_data_q;
  logic [EVENT_NUM-1:0]        ev_oprand_q;
  logic                        late_q;
  logic                        sync_err_q;
  logic [CNT_WIDTH-1:0]        ev_cnt_q;

  logic [TIME_WIDTH-1:0] cnt;
  logic [TIME_WIDTH-1:0] w_eff;
  logic                  head_loaded;
  logic                  slot_free;
  logic                  fire;
  logic                  pop;
  logic                  sync_mismatch;

  assign head_loaded = (state_q == S_WAIT);
  // A zero interval still costs one cycle so strobes never collide.
  assign w_eff       = (head_w_q == '0) ? TIME_WIDTH'(1) : head_w_q;

  assign fire          = run_i & ~clr_i & head_loaded & (cnt >= w_eff);
  assign slot_free     = ~head_loaded | fire;
  assign pop           = run_i & ~clr_i & tiq_rd_valid & evq_rd_valid & slot_free;
  assign sync_mismatch = run_i & ~clr_i & (tiq_rd_valid != evq_rd_valid) & slot_free;

  assign tiq_rd_ready = pop;
  assign evq_rd_ready = pop;

  qpu_time_cnt #(
    .WIDTH (TIME_WIDTH)
  ) u_time_cnt (
    .clk     (clk),
    .rst     (rst),
    .run_i   (run_i),
    .clr_i   (clr_i),
    .load1_i (fire),
    .cnt_o   (cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      head_w_q      <= '0;
      head_data_q   <= '0;
      head_oprand_q <= '0;
      ev_valid_q    <= 1'b0;
      ev_data_q     <= '0;
      ev_oprand_q   <= '0;
      late_q        <= 1'b0;
      sync_err_q    <= 1'b0;
      ev_cnt_q      <= '0;
    end else if (clr_i) begin
      state_q       <= S_IDLE;
      head_w_q      <= '0;
      head_data_q   <= '0;
      head_oprand_q <= '0;
      ev_valid_q    <= 1'b0;
      ev_data_q     <= '0;
      ev_oprand_q   <= '0;
      late_q        <= 1'b0;
      sync_err_q    <= 1'b0;
      ev_cnt_q      <= '0;
    end else begin
      ev_valid_q  <= fire;
      ev_data_q   <= fire ? head_data_q : '0;
      ev_oprand_q <= fire ? head_oprand_q : '0;
      if (fire) begin
        ev_cnt_q <= ev_cnt_q + CNT_WIDTH'(1);
      end
      // Head showed up past its slot: it issued as early as possible instead.
      if (fire && (cnt > w_eff)) begin
        late_q <= 1'b1;
      end
      if (sync_mismatch) begin
        sync_err_q <= 1'b1;
      end
      if (pop) begin
        state_q       <= S_WAIT;
        head_w_q      <= tiq_rd_data;
        head_data_q   <= evq_rd_data;
        head_oprand_q <= evq_rd_oprand;
      end else if (fire) begin
        state_q <= S_IDLE;
      end
    end
  end

  assign ev_o_valid  = ev_valid_q;
  assign ev_o_data   = ev_data_q;
  assign ev_o_oprand = ev_oprand_q;
  assign late_o      = late_q;
  assign sync_err_o  = sync_err_q;
  assign ev_cnt_o    = ev_cnt_q;
  assign busy_o      = head_loaded | tiq_rd_valid | evq_rd_valid;

endmodule
